// File: rtl/flash_stream_ram_writer.sv
// flash_stream_ram_writer
//   Packs an incoming SPI-flash byte stream little-endian into 32-bit words
//   and writes them with byteenable to consecutive RAM word addresses over
//   an Avalon-MM single-word master port.
//   Optional feature macro: FLASH_RAM_WRITER_CHECKSUM_EN builds a 16-bit
//   wrapping sum of accepted bytes; otherwise checksum reads as zero.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; stream and master port inactive
//   FILL   | accepting bytes into the current word (s_ready high)
//   WRITE  | presenting the packed word, waiting for waitrequest low
//   DONE   | one-cycle done pulse, then back to IDLE
module flash_stream_ram_writer #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = ADDR_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  output logic              m_chipselect,
  output logic              m_write,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bytes_done,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic [1:0]        lane_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  bytes_done_q;
  logic              s_ready_q;
  logic              m_write_q;
  logic              busy_q;
  logic              done_q;

  logic              start_acc;
  logic              byte_acc;
  logic              word_last;
  logic [1:0]        lane_d;
  logic [CNT_W-1:0]  remaining_d;
  logic [CNT_W-1:0]  bytes_done_d;
  logic [ADDR_W-1:0] addr_d;

  // handshake qualifiers and next-value arithmetic for the FSM
  always_comb begin
    start_acc    = start & (state_q == ST_IDLE);
    byte_acc     = s_valid & s_ready_q;
    word_last    = (lane_q == 2'd3) | (remaining_q == CNT_W'(1));
    lane_d       = lane_q + 2'd1;
    remaining_d  = remaining_q - CNT_W'(1);
    bytes_done_d = bytes_done_q + CNT_W'(1);
    addr_d       = addr_q + ADDR_W'(1);
  end

  // transfer sequencer with registered stream/master/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      lane_q       <= '0;
      remaining_q  <= '0;
      bytes_done_q <= '0;
      s_ready_q    <= 1'b0;
      m_write_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            bytes_done_q <= '0;
            if (byte_count != '0) begin
              addr_q      <= start_addr;
              remaining_q <= byte_count;
              lane_q      <= '0;
              data_q      <= '0;
              be_q        <= '0;
              s_ready_q   <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= ST_FILL;
            end else begin
              // empty transfer: pulse done without ever going busy
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          if (byte_acc) begin
            data_q[{lane_q, 3'b000} +: 8] <= s_data;
            be_q[lane_q]                  <= 1'b1;
            lane_q                        <= lane_d;
            remaining_q                   <= remaining_d;
            bytes_done_q                  <= bytes_done_d;
            if (word_last) begin
              s_ready_q <= 1'b0;
              m_write_q <= 1'b1;
              state_q   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (!m_waitrequest) begin
            // clearing data keeps unused lanes of a partial word at zero
            m_write_q <= 1'b0;
            addr_q    <= addr_d;
            be_q      <= '0;
            data_q    <= '0;
            lane_q    <= '0;
            if (remaining_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              s_ready_q <= 1'b1;
              state_q   <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FLASH_RAM_WRITER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // running wrapping sum of accepted bytes, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (byte_acc) begin
      checksum_q <= checksum_q + {8'h00, s_data};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign s_ready      = s_ready_q;
  assign m_address    = addr_q;
  assign m_byteenable = be_q;
  assign m_writedata  = data_q;
  assign m_write      = m_write_q;
  assign m_chipselect = m_write_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bytes_done   = bytes_done_q;

endmodule

// File: tb/tb_flash_stream_ram_writer.sv
// Testbench for flash_stream_ram_writer: table-driven directed transfers,
// hand-written reset and stall sequences, and randomized transfers checked
// against a word-level packing model.
module tb_flash_stream_ram_writer;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = ADDR_W + 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  byte_count;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata;
  logic              m_chipselect;
  logic              m_write;
  logic              m_waitrequest;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bytes_done;
  logic [15:0]       checksum;

  flash_stream_ram_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_writedata(m_writedata), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_waitrequest(m_waitrequest), .busy(busy), .done(done),
    .bytes_done(bytes_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        be;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    int                n;
    logic [63:0]       pat;
    int                stall;
    bit                ign;
    logic [ADDR_W-1:0] fa;
    logic [31:0]       fd;
    logic [3:0]        fbe;
    logic [ADDR_W-1:0] la;
    logic [31:0]       ld;
    logic [3:0]        lbe;
    logic [15:0]       cs;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  bq[$];
  wr_t         exp_q[$];
  logic [15:0] last_csum;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] csum_exp(input logic [15:0] raw);
`ifdef FLASH_RAM_WRITER_CHECKSUM_EN
    return raw;
`else
    return 16'h0000;
`endif
  endfunction

  // reference: byte i lands in word i/4, lane i%4, at base+i/4 modulo RAM size
  function automatic logic [15:0] build_model(input logic [ADDR_W-1:0] a);
    logic [15:0] s = 16'h0;
    exp_q.delete();
    for (int i = 0; i < bq.size(); i += 4) begin
      wr_t w;
      w.a  = ADDR_W'(int'(a) + i / 4);
      w.d  = '0;
      w.be = '0;
      for (int j = 0; j < 4 && i + j < bq.size(); j++) begin
        w.d[8*j +: 8] = bq[i+j];
        w.be[j]       = 1'b1;
      end
      exp_q.push_back(w);
    end
    foreach (bq[k]) s = s + 16'(bq[k]);
    return s;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_write"}, m_write, 0);
    chk({tag, "_m_cs"}, m_chipselect, 0);
    chk({tag, "_m_be"}, m_byteenable, 0);
    chk({tag, "_m_wdata"}, m_writedata, 0);
    chk({tag, "_m_addr"}, m_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_bytes_done"}, bytes_done, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // runs one transfer of the bytes in bq; called and returns on a negedge
  task automatic xfer(input logic [ADDR_W-1:0] a, input int v_pct, input int wr_pct,
                      input int stall_first, input bit ign_start,
                      output wr_t first_w, output wr_t last_w);
    int          n = bq.size();
    int          idx = 0, t0, last_wr = -1, stalls = 0, nwr = 0, first_cycles = 0;
    int          nwords = (n + 3) / 4;
    bit          held = 0, got_done = 0;
    wr_t         hv, w;
    logic [15:0] cs_raw = build_model(a);
    first_w = '{default: '0};
    last_w  = '{default: '0};

    @(negedge clk);
    chk("csum_stable_idle", checksum, last_csum);
    s_valid    = 1'b1;
    s_data     = 8'hE7;
    start      = 1'b1;
    start_addr = a;
    byte_count = CNT_W'(n);
    t0         = cyc;
    @(negedge clk);
    start      = 1'b0;
    start_addr = ~a;
    byte_count = '1;
    s_valid    = 1'b0;

    if (n == 0) begin
      chk("zero_done_T1", done, 1);
      chk("zero_busy_T1", busy, 0);
      chk("zero_no_write", m_write, 0);
      chk("zero_bytes_done", bytes_done, 0);
      @(negedge clk);
      chk("zero_done_pulse_end", done, 0);
      chk("zero_busy_after", busy, 0);
      chk("zero_no_write_after", m_write, 0);
      last_csum = 16'h0000;
      return;
    end

    chk("busy_T1", busy, 1);
    chk("ready_T1", s_ready, 1);

    for (int guard = 0; guard < 20000 && !got_done; guard++) begin
      if (ign_start) begin
        start      = (guard == 3);
        start_addr = 10'h2AA;
        byte_count = CNT_W'(5);
      end
      s_valid = (idx < n) && ($urandom_range(99) < v_pct);
      s_data  = (idx < n) ? bq[idx] : 8'($urandom);
      if (m_write && nwr == 0 && first_cycles < stall_first) m_waitrequest = 1'b1;
      else m_waitrequest = ($urandom_range(99) < wr_pct);

      if (done) begin
        got_done = 1;
        chk("done_after_last_write", cyc, last_wr + 1);
        chk("busy_low_at_done", busy, 0);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("bytes_done_final", bytes_done, n);
        chk("bytes_offered_all", idx, n);
        chk("checksum_final", checksum, csum_exp(cs_raw));
        if (v_pct == 100) chk("transfer_cycles", cyc, t0 + 1 + n + nwords + stalls);
        if (stall_first > 0) chk("stalled_write_cycles", first_cycles, stall_first + 1);
      end else begin
        chk("busy_during", busy, 1);
        if (held) begin
          chk("stall_addr_stable", m_address, hv.a);
          chk("stall_data_stable", m_writedata, hv.d);
          chk("stall_be_stable", m_byteenable, hv.be);
        end
        if (m_write) begin
          chk("cs_with_write", m_chipselect, 1);
          chk("ready_low_in_write", s_ready, 0);
          if (nwr == 0) first_cycles++;
          hv.a = m_address; hv.d = m_writedata; hv.be = m_byteenable;
          if (m_waitrequest) begin
            held = 1;
            stalls++;
          end else begin
            held = 0;
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 1, 0);
            end else begin
              w = exp_q.pop_front();
              chk("wr_addr", m_address, w.a);
              chk("wr_data", m_writedata, w.d);
              chk("wr_be", m_byteenable, w.be);
            end
            if (nwr == 0) first_w = hv;
            last_w  = hv;
            nwr++;
            last_wr = cyc;
          end
        end else begin
          held = 0;
          chk("cs_idle", m_chipselect, 0);
        end
        if (s_valid && s_ready) idx++;
        @(negedge clk);
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    start         = 1'b0;
    s_valid       = 1'b0;
    m_waitrequest = 1'b0;
    last_csum     = csum_exp(cs_raw);
  endtask

  vec_t vt[7];

  initial begin
    wr_t fw, lw;
    reset = 1'b1; start = 1'b0; start_addr = '0; byte_count = '0;
    s_data = '0; s_valid = 1'b0; m_waitrequest = 1'b0;
    last_csum = 16'h0000;

    vt[0] = '{10'h010, 8, 64'h0807060504030201, 0, 1'b0, 10'h010, 32'h04030201, 4'hF, 10'h011, 32'h08070605, 4'hF, 16'h0024};
    vt[1] = '{10'h020, 6, 64'h0000FFEEDDCCBBAA, 0, 1'b1, 10'h020, 32'hDDCCBBAA, 4'hF, 10'h021, 32'h0000FFEE, 4'h3, 16'h04FB};
    vt[2] = '{10'h040, 8, 64'h0807060504030201, 3, 1'b0, 10'h040, 32'h04030201, 4'hF, 10'h041, 32'h08070605, 4'hF, 16'h0024};
    vt[3] = '{10'h3FF, 8, 64'h1122334455667788, 0, 1'b0, 10'h3FF, 32'h55667788, 4'hF, 10'h000, 32'h11223344, 4'hF, 16'h0264};
    vt[4] = '{10'h100, 1, 64'h000000000000005A, 0, 1'b0, 10'h100, 32'h0000005A, 4'h1, 10'h100, 32'h0000005A, 4'h1, 16'h005A};
    vt[5] = '{10'h0AB, 3, 64'h0000000000C0FFEE, 0, 1'b0, 10'h0AB, 32'h00C0FFEE, 4'h7, 10'h0AB, 32'h00C0FFEE, 4'h7, 16'h02AD};
    vt[6] = '{10'h055, 0, 64'h0, 0, 1'b0, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0, 16'h0000};

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      bq.delete();
      for (int j = 0; j < vt[v].n; j++) bq.push_back(vt[v].pat[8*j +: 8]);
      xfer(vt[v].a, 100, 0, vt[v].stall, vt[v].ign, fw, lw);
      if (vt[v].n != 0) begin
        chk("tbl_first_addr", fw.a, vt[v].fa);
        chk("tbl_first_data", fw.d, vt[v].fd);
        chk("tbl_first_be", fw.be, vt[v].fbe);
        chk("tbl_last_addr", lw.a, vt[v].la);
        chk("tbl_last_data", lw.d, vt[v].ld);
        chk("tbl_last_be", lw.be, vt[v].lbe);
      end
      chk("tbl_checksum", checksum, csum_exp(vt[v].cs));
    end

    // reset after two of four bytes: no write, everything back to reset values
    @(negedge clk);
    start = 1'b1; start_addr = 10'h200; byte_count = CNT_W'(4);
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h11;
    @(negedge clk);
    s_data = 8'h22;
    @(negedge clk);
    chk("mid_bytes_done", bytes_done, 2);
    chk("mid_no_write", m_write, 0);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_no_write", m_write, 0);
    chk("post_rst_idle_ready", s_ready, 0);
    last_csum = 16'h0000;
    bq = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    xfer(10'h200, 100, 0, 0, 1'b0, fw, lw);
    chk("post_rst_first_data", fw.d, 32'h34333231);
    chk("post_rst_last_data", lw.d, 32'h00000035);

    // randomized transfers with irregular valid and waitrequest
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 40);
      bq.delete();
      for (int j = 0; j < n; j++) bq.push_back(8'($urandom));
      xfer(ADDR_W'($urandom), (r % 3 == 0) ? 100 : 60, $urandom_range(0, 50), 0, (r == 5), fw, lw);
    end

    // longer than the RAM: addresses wrap and overwrite
    bq.delete();
    for (int j = 0; j < 4104; j++) bq.push_back(8'($urandom));
    xfer(10'h3F0, 100, 0, 0, 1'b0, fw, lw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
